// File: rtl/sequential_addsub.sv
// sequential_addsub: iterative WIDTH-bit adder/subtractor using repeated XOR/AND carry
// propagation, one step per clock, finishing as soon as the carry vector is zero.
// Latency: N+1 cycles from accept to out_valid, where N is the number of nonzero-carry steps (0..WIDTH).
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset (rst overrides everything)
//   in_valid/in_ready   operand handshake; a, b, sub are sampled on the accept edge only
//   out_valid/out_ready result handshake; sum, carry, overflow are valid with out_valid
//   sub                 0: a+b, 1: a-b computed as a + ~b + 1
//   carry               carry-out; in subtract mode 1 means no borrow (a >= b unsigned)
//   overflow            signed two's-complement overflow
// Optional feature macro SEQ_ADDSUB_CYCLES_EN adds output "cycles" holding N+1 for the
// result being presented (valid with out_valid, resets to 0).

module sequential_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
`ifdef SEQ_ADDSUB_CYCLES_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cry;
  logic             cout;
  logic             a_msb;
  logic             b_msb;

  // Effective B operand (inverted for subtract) and the carry terms it produces.
  logic [WIDTH-1:0] be;
  logic [WIDTH-1:0] gen_load;
  logic [WIDTH-1:0] gen_step;

  assign be       = sub ? ~b : b;
  assign gen_load = a & be;
  assign gen_step = acc & cry;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)   state_nxt = RUN;
      RUN:  if (cry == '0)  state_nxt = DONE;
      DONE: if (out_ready)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Datapath. The "+1" of subtraction rides in as cry[0] on load, so the
  // same propagation loop handles both modes. Carries shifted out of the
  // top bit are folded into cout rather than kept in cry.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cry   <= '0;
      cout  <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= a ^ be;
            cry   <= {gen_load[WIDTH-2:0], sub};
            cout  <= gen_load[WIDTH-1];
            a_msb <= a[WIDTH-1];
            b_msb <= be[WIDTH-1];
          end
        end
        RUN: begin
          if (cry != '0) begin
            acc  <= acc ^ cry;
            cry  <= {gen_step[WIDTH-2:0], 1'b0};
            cout <= cout | gen_step[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_ADDSUB_CYCLES_EN
  localparam int CW = $clog2(WIDTH+2);
  logic [CW-1:0] cnt;

  // Starts at 1 on accept (the final RUN->DONE edge) and counts each carry step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (in_valid)  cnt <= CW'(1);
        RUN:     if (cry != '0) cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

  assign cycles = cnt;
`endif

  // Outputs are zero outside DONE so nothing partial is ever visible.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = 1'b0;
    sum       = '0;
    carry     = 1'b0;
    overflow  = 1'b0;
    if (state == DONE) begin
      out_valid = 1'b1;
      sum       = acc;
      carry     = cout;
      overflow  = (a_msb == b_msb) && (acc[WIDTH-1] != a_msb);
    end
  end

endmodule

// File: tb/tb_sequential_addsub.sv
module tb_sequential_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;
  logic       overflow;
`ifdef SEQ_ADDSUB_CYCLES_EN
  logic [3:0] cycles;
`endif

  int checks = 0;
  int errors = 0;

  sequential_addsub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
`ifdef SEQ_ADDSUB_CYCLES_EN
    ,
    .cycles    (cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one operation from IDLE. elat < 0 means only bound-check the latency.
  // While waiting, junk operands are waved at in_valid to prove they are ignored.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic [7:0] esum, input logic ecar,
                        input logic eovf, input int elat, input int hold);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (elat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(elat));
    else           chk({tag, "_latency_le9"}, 32'(lat >= 1 && lat <= 9), 32'd1);
    chk({tag, "_sum"},      32'(sum),      32'(esum));
    chk({tag, "_carry"},    32'(carry),    32'(ecar));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eovf));
`ifdef SEQ_ADDSUB_CYCLES_EN
    chk({tag, "_cycles"}, 32'(cycles), 32'(lat));
`endif
    // Back-pressure: result must hold and new operands must be refused.
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_sum"},   {23'd0, sum, carry, overflow}, {23'd0, esum, ecar, eovf});
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ret_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ret_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb, rbe;
    logic       rs;
    logic [8:0] full;
    logic       rovf;
    int         wait_cnt;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state, with in_valid asserted to show rst dominates
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_carry",     32'(carry),     32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
`ifdef SEQ_ADDSUB_CYCLES_EN
    chk("rst_cycles",    32'(cycles),    32'd0);
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, 0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1, 0);
    run_op("add_12_00", 8'h12, 8'h00, 1'b0, 8'h12, 1'b0, 1'b0, 1, 0);
    run_op("sub_00_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 9, 0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, -1, 0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1, 0);
    // Back-pressure: 5 cycles with out_ready low
    run_op("bp_3c_44",  8'h3C, 8'h44, 1'b0, 8'h80, 1'b0, 1'b1, -1, 5);

    // Reset during RUN aborts with no result
    a = 8'hFF; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_running", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum",       32'(sum),       32'd0);
    wait_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) wait_cnt++;
    end
    chk("abort_no_result", 32'(wait_cnt), 32'd0);
    run_op("after_abort", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, 0);

    // Random operations against an arithmetic reference
    for (int n = 0; n < 3000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      rbe  = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, rbe} + {8'd0, rs};
      rovf = (ra[7] == rbe[7]) && (full[7] != ra[7]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("rand", ra, rb, rs, full[7:0], full[8], rovf, -1, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
